mysystem_tone_gen: RTL
======================

Name: mysystem_tone_gen

Overview:
- Consumes the 8-bit note code driven by the Nios II PIO address port and turns it into a square wave for the board buzzer.
- Maps the semitone/octave code through a fixed half-period table and counts system clocks to generate the tone.
- Note changes are glitch-free: a new pitch takes effect only at a half-period boundary. Rests silence the output immediately.
- Sits between the PIO output and the buzzer pin. Runs on the 50 MHz system clock.

Parameters:
- CNT_W, 18, half-period counter width; must hold the largest table entry, 191117.
- OCT_MAX, 4, highest octave shift; larger octave fields clamp to this value.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- note_code  input  8  from PIO out_port. [3:0] semitone: 0 = rest, 1..12 = C..B, 13..15 = rest. [6:4] octave shift. [7] ignored.
- tone_out  output  1  square wave to the buzzer.
- playing  output  1  high while a non-rest note is sounding.
- cur_code  output  8  note_code value currently sounding, with bit 7 cleared; 0x00 during a rest.
- cycle_tick  output  1  one-clock pulse on each falling edge of tone_out (end of a full period).

Behaviour:
- Reset (async assert, sync release): all registers 0. tone_out=0, playing=0, cur_code=0, cycle_tick=0, pipeline valid flags 0.
- Base half-period table, octave 0, 50 MHz, value = round(25e6/f):
  - C 191117, C# 180388, D 170265, D# 160710, E 151690, F 143176
  - F# 135135, G 127551, G# 120395, A 113636, A# 107259, B 101239
- Stage 1 (edge E1): code_q <= {1'b0, note_code[6:0]}.
- Stage 2 (edge E2):
  - oct = min(code_q[6:4], OCT_MAX).
  - pend_half <= table[semitone] >> oct, a logical shift that truncates.
  - pend_rest <= 1 if semitone is 0 or 13..15.
  - pend_code <= code_q.
  - Stage 2 updates every cycle; no handshake.
- Stage 3, tone FSM with states IDLE and RUN:
  - IDLE, pend_rest=0 → RUN. tone_out<=1, cnt<=pend_half-1, act_half<=pend_half, cur_code<=pend_code, playing<=1.
  - Net latency: tone_out rises at the 3rd clock edge after note_code changes.
  - RUN, pend_rest=1 → IDLE on that same edge. tone_out<=0, playing<=0, cur_code<=0, cnt<=0, no cycle_tick. A rest mid-period truncates the wave.
  - RUN, cnt!=0: cnt<=cnt-1; tone_out holds.
  - RUN, cnt==0: tone_out toggles.
    - If pend_code != cur_code: act_half<=pend_half, cnt<=pend_half-1, cur_code<=pend_code.
    - Otherwise cnt<=act_half-1.
  - Each tone_out level therefore lasts exactly act_half clocks; the period is 2*act_half.
  - A new note applied at a boundary is held for exactly the new half-period.
- cycle_tick: registered. It is 1 in the cycle immediately after tone_out goes 1→0 in RUN, else 0.
- Rapid changes: only the pend_* value present at the boundary edge is applied. Intermediate codes are dropped.
- Same-pitch alias: codes differing only in bit 7 are treated as identical. No restart, no phase change.
- Octave clamp: octave fields 5..7 behave exactly as octave 4.
- Reset mid-note: output goes to 0 asynchronously. After release the block is in IDLE and restarts from stage 1.
- Counter arithmetic is unsigned CNT_W bits. The minimum table value after shifting (6327) is much greater than 1, so there is no underflow case.

Test Plan:
- Reset, then note_code=0x4A (A, octave 4):
  - tone_out rises at the 3rd edge, playing=1, cur_code=0x4A.
  - High 7102 clocks, low 7102 clocks.
  - cycle_tick is a single pulse after each falling edge.
- While 0x4A is playing, switch to 0x41 (C, octave 4) mid-high-phase:
  - The current high phase completes at 7102 clocks.
  - The next low phase lasts 11944 clocks; cur_code becomes 0x41 on that edge.
  - No runt pulse.
- While playing, set note_code=0x00:
  - Three edges later tone_out=0, playing=0, cur_code=0x00, and no cycle_tick.
  - Semitone 0x0E (rest) gives the identical response.
- note_code=0x7A (octave 7): half-period 7102, identical to 0x4A.
  - Then switch to 0xCA: no phase disturbance, cur_code stays 0x4A.
- Toggle 0x4A → 0x41 → 0x4A within 2 cycles, well before the boundary: the wave continues at 7102 with no change.
- Assert reset_n low mid-period: tone_out and playing drop to 0 immediately without waiting for a clock.
  - Release with code 0x0A held: tone_out rises 3 edges later with half-period 113636.

Source files
------------

// File: rtl/mysystem_tone_gen.sv
// mysystem_tone_gen: PIO note code to buzzer square wave.
// Three-stage pipe: capture, table lookup, glitch-free tone FSM.
module mysystem_tone_gen #(
  parameter int CNT_W   = 18,
  parameter int OCT_MAX = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] note_code,
  output logic       tone_out,
  output logic       playing,
  output logic [7:0] cur_code,
  output logic       cycle_tick
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [2:0] LP_OCT = 3'(OCT_MAX);

  logic [7:0]       r_code_q;
  logic             r_s1_vld;
  logic [CNT_W-1:0] r_pend_half;
  logic             r_pend_rest;
  logic [7:0]       r_pend_code;
  logic             r_s2_vld;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_act_half;
  logic [7:0]       r_cur_code;
  logic             r_tone;
  logic             r_playing;
  logic             r_tick;

  logic [7:0]       w_code_in;
  logic [3:0]       w_semi;
  logic [2:0]       w_oct;
  logic [CNT_W-1:0] w_base;
  logic             w_rest;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_act_nxt;
  logic [7:0]       w_cur_nxt;
  logic             w_tone_nxt;
  logic             w_play_nxt;
  logic             w_tick_nxt;

  assign w_code_in = note_code & 8'h7F;
  assign w_semi    = r_code_q[3:0];
  assign w_oct     = (r_code_q[6:4] > LP_OCT) ?
                     LP_OCT : r_code_q[6:4];
  assign w_rest    = (w_semi == 4'd0) ||
                     (w_semi > 4'd12);

  // Octave-0 half-period, in 50 MHz clocks.
  always_comb begin
    w_base = '0;
    unique case (w_semi)
      4'd1:    w_base = CNT_W'(191117);
      4'd2:    w_base = CNT_W'(180388);
      4'd3:    w_base = CNT_W'(170265);
      4'd4:    w_base = CNT_W'(160710);
      4'd5:    w_base = CNT_W'(151690);
      4'd6:    w_base = CNT_W'(143176);
      4'd7:    w_base = CNT_W'(135135);
      4'd8:    w_base = CNT_W'(127551);
      4'd9:    w_base = CNT_W'(120395);
      4'd10:   w_base = CNT_W'(113636);
      4'd11:   w_base = CNT_W'(107259);
      4'd12:   w_base = CNT_W'(101239);
      default: w_base = '0;
    endcase
  end

  // Stages 1 and 2: capture code, then resolve pitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_code_q    <= '0;
      r_s1_vld    <= 1'b0;
      r_pend_half <= '0;
      r_pend_rest <= 1'b0;
      r_pend_code <= '0;
      r_s2_vld    <= 1'b0;
    end else begin
      r_code_q    <= w_code_in;
      r_s1_vld    <= 1'b1;
      r_pend_half <= w_base >> w_oct;
      r_pend_rest <= w_rest;
      r_pend_code <= r_code_q;
      r_s2_vld    <= r_s1_vld;
    end
  end

  // Tone FSM next state: pitch changes only at a boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_act_nxt   = r_act_half;
    w_cur_nxt   = r_cur_code;
    w_tone_nxt  = r_tone;
    w_play_nxt  = r_playing;
    w_tick_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_s2_vld && !r_pend_rest) begin
          w_state_nxt = S_RUN;
          w_tone_nxt  = 1'b1;
          w_cnt_nxt   = r_pend_half - CNT_W'(1);
          w_act_nxt   = r_pend_half;
          w_cur_nxt   = r_pend_code;
          w_play_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (r_pend_rest) begin
          w_state_nxt = S_IDLE;
          w_tone_nxt  = 1'b0;
          w_play_nxt  = 1'b0;
          w_cur_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_tone_nxt = ~r_tone;
          w_tick_nxt = r_tone;
          if (r_pend_code != r_cur_code) begin
            w_act_nxt = r_pend_half;
            w_cnt_nxt = r_pend_half - CNT_W'(1);
            w_cur_nxt = r_pend_code;
          end else begin
            w_cnt_nxt = r_act_half - CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tone FSM state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_act_half <= '0;
      r_cur_code <= '0;
      r_tone     <= 1'b0;
      r_playing  <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_act_half <= w_act_nxt;
      r_cur_code <= w_cur_nxt;
      r_tone     <= w_tone_nxt;
      r_playing  <= w_play_nxt;
      r_tick     <= w_tick_nxt;
    end
  end

  assign tone_out   = r_tone;
  assign playing    = r_playing;
  assign cur_code   = r_cur_code;
  assign cycle_tick = r_tick;

endmodule
